// File: rtl/scarv_cop_mp_wb_pkg.sv
// Shared definitions for the multi-precision ALU writeback stage.
//  - wb_beat_e : beat counter state (2-bit encoding) for pair writebacks.
//  - PAIR_W    : width of a register-pair index; a pair index concatenated
//                with the hi/lo select yields a 4-bit CPR index.
//  - pair_addr : builds the CPR index {pair, hi} for one half of a pair.
package scarv_cop_mp_wb_pkg;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,  // next beat writes the low word of the pair
    S_HI  = 2'd1,  // next beat writes the high word of the pair
    S_OVF = 2'd2   // pair already complete; further beats are illegal
  } wb_beat_e;

  localparam int PAIR_W = 3;
  localparam int CPR_W  = PAIR_W + 1;

  function automatic logic [CPR_W-1:0] pair_addr(input logic [PAIR_W-1:0] p,
                                                 input logic              hi);
    return {p, hi};
  endfunction

endpackage

// File: rtl/scarv_cop_mp_wb.sv
// Writeback stage between scarv_cop_malu and the CPR register file.
// Turns ALU write beats into CPR writes through a one-entry output register,
// steering pair results to {P,0} then {P,1}.
// Ports:
//  g_clk, g_resetn        clock, synchronous active-low reset
//  wb_ivalid/wb_idone     instruction in flight / completing this cycle
//  wb_pair, wb_rdm_in_rs  pair-result mode, pair index source select
//  id_rd/id_rdm/id_rsm    single destination / pair indices (rd, rs fields)
//  malu_cpr_rd_ben/wdata  ALU write beat (non-zero ben marks a beat)
//  cpr_wready             CPR write port accepts the presented write
//  cpr_wen/waddr/wben/wdata  registered CPR write
//  wb_stall               combinational backpressure to the ALU FSM
//  wb_err                 one-cycle pulse on an illegal third pair beat
module scarv_cop_mp_wb
  import scarv_cop_mp_wb_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        wb_ivalid,
  input  logic        wb_idone,
  input  logic        wb_pair,
  input  logic        wb_rdm_in_rs,
  input  logic [3:0]  id_rd,
  input  logic [2:0]  id_rdm,
  input  logic [2:0]  id_rsm,
  input  logic [3:0]  malu_cpr_rd_ben,
  input  logic [31:0] malu_cpr_rd_wdata,
  input  logic        cpr_wready,
  output logic        cpr_wen,
  output logic [3:0]  cpr_waddr,
  output logic [3:0]  cpr_wben,
  output logic [31:0] cpr_wdata,
  output logic        wb_stall,
  output logic        wb_err
);

  wb_beat_e          r_state, w_state_nxt;
  logic              r_wen;
  logic [3:0]        r_waddr;
  logic [3:0]        r_wben;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic [PAIR_W-1:0] w_pidx;
  logic              w_beat;
  logic              w_accept;
  logic              w_drop;
  logic              w_load;
  logic [3:0]        w_addr;

  assign wb_stall  = r_wen && !cpr_wready;
  assign w_pidx    = wb_rdm_in_rs ? id_rsm : id_rdm;
  assign w_beat    = wb_ivalid && (malu_cpr_rd_ben != 4'd0);
  assign w_accept  = w_beat && !wb_stall;
  // Only pair mode can reach S_OVF, so a dropped beat implies pair mode.
  assign w_drop    = w_accept && wb_pair && (r_state == S_OVF);
  assign w_load    = w_accept && !w_drop;
  assign w_addr    = wb_pair ? pair_addr(w_pidx, r_state == S_HI) : id_rd;

  // Beat counter state register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) r_state <= S_LO;
    else           r_state <= w_state_nxt;
  end

  // Beat counter next state. End of instruction (or no instruction) wins
  // over beat advancement, so a beat arriving with wb_idone still uses the
  // current state for its address and the next instruction starts at S_LO.
  always_comb begin
    w_state_nxt = r_state;
    if (!wb_ivalid || (wb_idone && !wb_stall)) begin
      w_state_nxt = S_LO;
    end else if (w_accept && wb_pair) begin
      case (r_state)
        S_LO:    w_state_nxt = S_HI;
        S_HI:    w_state_nxt = S_OVF;
        default: w_state_nxt = S_OVF;
      endcase
    end
  end

  // One-entry output register. A new accepted beat overwrites the entry in
  // the same cycle the previous one is taken (ready high), so no bubble.
  // While stalled, nothing is accepted, so the entry holds.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_wen   <= 1'b0;
      r_waddr <= 4'd0;
      r_wben  <= 4'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_drop;
      if (w_load) begin
        r_wen   <= 1'b1;
        r_waddr <= w_addr;
        r_wben  <= malu_cpr_rd_ben;
        r_wdata <= malu_cpr_rd_wdata;
      end else if (cpr_wready) begin
        r_wen   <= 1'b0;
      end
    end
  end

  assign cpr_wen   = r_wen;
  assign cpr_waddr = r_waddr;
  assign cpr_wben  = r_wben;
  assign cpr_wdata = r_wdata;
  assign wb_err    = r_err;

endmodule

// File: tb/tb_scarv_cop_mp_wb.sv
// Directed bench for scarv_cop_mp_wb. Expected CPR writes are pushed to a
// queue as beats are driven; a monitor pops and compares each write that the
// CPR port takes (cpr_wen && cpr_wready).
module tb_scarv_cop_mp_wb;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        wb_ivalid, wb_idone, wb_pair, wb_rdm_in_rs;
  logic [3:0]  id_rd;
  logic [2:0]  id_rdm, id_rsm;
  logic [3:0]  malu_cpr_rd_ben;
  logic [31:0] malu_cpr_rd_wdata;
  logic        cpr_wready;
  logic        cpr_wen;
  logic [3:0]  cpr_waddr, cpr_wben;
  logic [31:0] cpr_wdata;
  logic        wb_stall, wb_err;

  typedef struct packed {
    logic [3:0]  addr;
    logic [3:0]  ben;
    logic [31:0] data;
  } wr_t;

  wr_t q_exp[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_mp_wb dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .wb_ivalid(wb_ivalid), .wb_idone(wb_idone), .wb_pair(wb_pair),
    .wb_rdm_in_rs(wb_rdm_in_rs), .id_rd(id_rd), .id_rdm(id_rdm),
    .id_rsm(id_rsm), .malu_cpr_rd_ben(malu_cpr_rd_ben),
    .malu_cpr_rd_wdata(malu_cpr_rd_wdata), .cpr_wready(cpr_wready),
    .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr), .cpr_wben(cpr_wben),
    .cpr_wdata(cpr_wdata), .wb_stall(wb_stall), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: inputs change 1 time unit after posedge, so values seen at
  // negedge hold through the next posedge, where the write is taken.
  always @(negedge g_clk) begin
    if (g_resetn === 1'b1 && cpr_wen === 1'b1 && cpr_wready === 1'b1) begin
      wr_t act, exp;
      act = '{addr: cpr_waddr, ben: cpr_wben, data: cpr_wdata};
      if (q_exp.size() == 0) begin
        chk("unexpected_write", 40'(act), 40'h0);
      end else begin
        exp = q_exp.pop_front();
        chk("write", 40'(act), 40'(exp));
      end
    end
  end

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] ben, input logic [31:0] d);
    wb_ivalid         = 1'b1;
    malu_cpr_rd_ben   = ben;
    malu_cpr_rd_wdata = d;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    q_exp.push_back('{addr: a, ben: b, data: d});
  endtask

  task automatic idle;
    wb_ivalid = 1'b0; wb_idone = 1'b0; malu_cpr_rd_ben = 4'd0;
  endtask

  initial begin
    g_resetn = 1'b0; wb_rdm_in_rs = 1'b0; wb_pair = 1'b0;
    id_rd = 4'd0; id_rdm = 3'd0; id_rsm = 3'd0; malu_cpr_rd_wdata = 32'd0;
    cpr_wready = 1'b1;
    idle();
    tick(); tick();
    chk("rst_wen",   40'(cpr_wen),   40'd0);
    chk("rst_waddr", 40'(cpr_waddr), 40'd0);
    chk("rst_wben",  40'(cpr_wben),  40'd0);
    chk("rst_wdata", 40'(cpr_wdata), 40'd0);
    chk("rst_err",   40'(wb_err),    40'd0);
    g_resetn = 1'b1;
    tick();

    // Pair add: P=id_rdm=3 -> 6 then 7
    wb_pair = 1'b1; id_rdm = 3'd3;
    beat(4'hF, 32'h11111111); push(4'd6, 4'hF, 32'h11111111);
    tick();
    chk("pair_lo_wen",  40'(cpr_wen),   40'd1);
    chk("pair_lo_addr", 40'(cpr_waddr), 40'd6);
    beat(4'hF, 32'h22222222); push(4'd7, 4'hF, 32'h22222222);
    tick();
    chk("pair_hi_addr", 40'(cpr_waddr), 40'd7);
    chk("pair_hi_data", 40'(cpr_wdata), 40'h22222222);
    malu_cpr_rd_ben = 4'd0; wb_idone = 1'b1;
    tick();
    chk("pair_drain_wen", 40'(cpr_wen), 40'd0);
    idle(); tick();

    // rs-pair: id_rsm=5, id_rdm=2 -> 10, 11
    wb_rdm_in_rs = 1'b1; id_rsm = 3'd5; id_rdm = 3'd2;
    beat(4'h3, 32'h0000BEEF); push(4'd10, 4'h3, 32'h0000BEEF);
    tick();
    chk("rs_lo_addr", 40'(cpr_waddr), 40'd10);
    beat(4'hC, 32'hCAFE0000); push(4'd11, 4'hC, 32'hCAFE0000); wb_idone = 1'b1;
    tick();
    chk("rs_hi_addr", 40'(cpr_waddr), 40'd11);
    chk("rs_hi_ben",  40'(cpr_wben),  40'hC);
    idle(); wb_rdm_in_rs = 1'b0; tick();

    // Backpressure in single mode: rd=9 stalled 3 cycles, then a second
    // beat replaces the entry in the cycle it drains.
    wb_pair = 1'b0; id_rd = 4'd9;
    beat(4'hF, 32'hAABBCCDD); push(4'd9, 4'hF, 32'hAABBCCDD);
    tick();
    cpr_wready = 1'b0;
    beat(4'hF, 32'h55555555);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall", 40'(wb_stall),  40'd1);
      tick();
      chk("bp_hold_addr", 40'(cpr_waddr), 40'd9);
      chk("bp_hold_data", 40'(cpr_wdata), 40'hAABBCCDD);
      chk("bp_hold_wen",  40'(cpr_wen),   40'd1);
    end
    cpr_wready = 1'b1; push(4'd9, 4'hF, 32'h55555555);
    #1;
    chk("bp_release", 40'(wb_stall), 40'd0);
    tick();
    chk("bp_replace_wen",  40'(cpr_wen),   40'd1);
    chk("bp_replace_data", 40'(cpr_wdata), 40'h55555555);
    chk("single_no_err",   40'(wb_err),    40'd0);
    malu_cpr_rd_ben = 4'd0; wb_idone = 1'b1;
    tick();
    idle(); tick();

    // Overflow: P=4, three beats -> 8, 9 written, third dropped, one err pulse
    wb_pair = 1'b1; id_rdm = 3'd4;
    beat(4'hF, 32'h00000001); push(4'd8, 4'hF, 32'h00000001);
    tick();
    beat(4'hF, 32'h00000002); push(4'd9, 4'hF, 32'h00000002);
    tick();
    chk("ovf_err_before", 40'(wb_err), 40'd0);
    beat(4'hF, 32'h00000003);
    tick();
    chk("ovf_err_pulse", 40'(wb_err),  40'd1);
    chk("ovf_dropped",   40'(cpr_wen), 40'd0);
    malu_cpr_rd_ben = 4'd0; wb_idone = 1'b1;
    tick();
    chk("ovf_err_clear", 40'(wb_err), 40'd0);
    idle(); tick();

    // Reset at S_HI with a stalled pending write
    id_rdm = 3'd1;
    beat(4'hF, 32'h12345678); push(4'd2, 4'hF, 32'h12345678);
    tick();
    cpr_wready = 1'b0; malu_cpr_rd_ben = 4'd0;
    tick();
    g_resetn = 1'b0;
    tick();
    q_exp.delete();   // reset discards the pending write
    chk("rr_wen",   40'(cpr_wen),   40'd0);
    chk("rr_addr",  40'(cpr_waddr), 40'd0);
    chk("rr_data",  40'(cpr_wdata), 40'd0);
    chk("rr_stall", 40'(wb_stall),  40'd0);
    g_resetn = 1'b1; cpr_wready = 1'b1; id_rdm = 3'd6;
    beat(4'hF, 32'h9ABCDEF0); push(4'd12, 4'hF, 32'h9ABCDEF0);
    tick();
    chk("rr_first_addr", 40'(cpr_waddr), 40'd12);
    wb_idone = 1'b1; malu_cpr_rd_ben = 4'd0;
    tick();
    idle(); tick();

    // Back-to-back: idone with beat, then new instruction next cycle
    id_rdm = 3'd2;
    beat(4'hF, 32'hA0000000); push(4'd4, 4'hF, 32'hA0000000);
    tick();
    beat(4'hF, 32'hA0000001); push(4'd5, 4'hF, 32'hA0000001); wb_idone = 1'b1;
    tick();
    chk("b2b_hi_addr", 40'(cpr_waddr), 40'd5);
    wb_idone = 1'b0; id_rdm = 3'd7;
    beat(4'hF, 32'hB0000000); push(4'd14, 4'hF, 32'hB0000000);
    tick();
    chk("b2b_wen",  40'(cpr_wen),   40'd1);
    chk("b2b_addr", 40'(cpr_waddr), 40'd14);
    idle();
    tick(); tick(); tick();
    chk("queue_empty", 40'(q_exp.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
